// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports and memory-side bus of the shared 256x8 memory arbiter.
interface mem_arbiter_if;
  logic       halt;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [7:0] dbg_addr, dbg_wdata;
  logic [7:0] rdata, mem_addr, mem_din, mem_dout;
  logic       mem_we;
  modport slave (
    input  halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_dout,
    output cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, rdata, mem_addr, mem_we, mem_din
  );
  modport master (
    output halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_dout,
    input  cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, rdata, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin (debug-first when halted) arbiter between CPU and debug ports
// in front of a synchronous 256x8 memory; all memory-side controls are registered.
module mem_arbiter (
  input logic        clk,
  input logic        reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, G_CPU, G_DBG} owner_t;
  owner_t owner, next_owner;
  logic last_dbg, rd_cpu, rd_dbg, cpu_el, dbg_el, pick_dbg;
  // The current owner still holds req on the edge its grant completes, so it is excluded.
  always_comb begin
    cpu_el     = bus.cpu_req && owner != G_CPU;
    dbg_el     = bus.dbg_req && owner != G_DBG;
    pick_dbg   = dbg_el && (!cpu_el || bus.halt || !last_dbg);
    next_owner = pick_dbg ? G_DBG : cpu_el ? G_CPU : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) owner <= IDLE;
    else        owner <= next_owner;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_dbg       <= 1'b1;
      rd_cpu         <= 1'b0;
      rd_dbg         <= 1'b0;
      bus.cpu_gnt    <= 1'b0;
      bus.dbg_gnt    <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dbg_rvalid <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 8'h00;
      bus.mem_din    <= 8'h00;
    end else begin
      last_dbg       <= next_owner == IDLE ? last_dbg : next_owner == G_DBG;
      bus.cpu_gnt    <= next_owner == G_CPU;
      bus.dbg_gnt    <= next_owner == G_DBG;
      bus.mem_we     <= next_owner == G_CPU ? bus.cpu_we : next_owner == G_DBG ? bus.dbg_we : 1'b0;
      if (next_owner != IDLE) begin
        bus.mem_addr <= pick_dbg ? bus.dbg_addr : bus.cpu_addr;
        bus.mem_din  <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
      end
      rd_cpu         <= next_owner == G_CPU && !bus.cpu_we;
      rd_dbg         <= next_owner == G_DBG && !bus.dbg_we;
      bus.cpu_rvalid <= rd_cpu;
      bus.dbg_rvalid <= rd_dbg;
    end
  end
  assign bus.rdata = bus.mem_dout;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the CPU's single synchronous 256x8 memory between the CPU datapath port (instruction fetch, LOAD, STORE) and a debug/loader port (program download, memory inspection). It sits between those requesters and the memory macro and owns the memory's address, write-enable and write-data inputs. Arbitration is round-robin while the CPU runs and debug-first while the CPU is halted. All memory-side controls are registered.

## Interface
- No parameters: data width 8, address width 8, fixed.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- halt  in  1  CPU halt flag from the control unit; selects debug priority.
- cpu_req  in  1  CPU access request; held, with its qualifiers stable, until cpu_gnt is sampled high.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  8  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_gnt  out  1  one-cycle pulse; the CPU access occupies the memory this cycle.
- cpu_rvalid  out  1  one-cycle pulse; read data for the CPU is on rdata.
- dbg_req, dbg_we, dbg_addr[7:0], dbg_wdata[7:0]  in  debug-port equivalents of the cpu_* inputs.
- dbg_gnt, dbg_rvalid  out  1  debug-port equivalents of cpu_gnt and cpu_rvalid.
- rdata  out  8  mem_dout passed through to both ports; qualified by *_rvalid.
- mem_addr  out  8  registered memory address.
- mem_we  out  1  registered memory write enable.
- mem_din  out  8  registered memory write data.
- mem_dout  in  8  memory read data; valid the cycle after the address is presented.

## Operation
- Owner register has three states:
  - IDLE: no grant.
  - G_CPU: CPU holds the memory.
  - G_DBG: debug port holds the memory.
- Arbitration at every rising edge, from the sampled requests:
  - Eligible set = requesters with req=1, excluding the current owner. The current owner's req is still high on the edge at which its grant completes.
  - One eligible requester: it wins.
  - Both eligible, halt=1: debug wins.
  - Both eligible, halt=0: the requester not in `last` wins.
  - None eligible: next owner = IDLE.
- On a win, at the same edge:
  - owner, `last` <= winner; winner's gnt <= 1.
  - mem_addr <= winner addr; mem_din <= winner wdata; mem_we <= winner we.
- When IDLE is next:
  - gnt <= 0, mem_we <= 0.
  - mem_addr and mem_din hold their values.
- Read tracking: rd_owner <= winner if winner we=0, else none. The corresponding *_rvalid is asserted the following cycle.
- Writes produce no rvalid.
- A sole continuous requester is granted every other cycle.
- With two continuous requesters, grants alternate every cycle; maximum wait is one access.
- A req dropped before it is granted is withdrawn without effect. Grants go only to requests sampled high.

## Timing
- Reset (asynchronous, while reset=0):
  - Forced to 0: cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we, mem_addr, mem_din.
  - owner = IDLE, rd_owner = none, `last` = DBG, so the CPU wins the first tie.
- Reset asserted mid-access clears any pending rvalid immediately. A write whose edge has not yet occurred is dropped.
- Request sampled at edge E:
  - gnt high and mem_* valid during cycle E..E+1.
  - The memory writes, or captures the read address, at edge E+1.
  - *_rvalid high and rdata valid during cycle E+1..E+2.
  - Read latency is 2 cycles from the request-sampling edge.
- gnt and rvalid are single-cycle pulses. A grant and a read-valid for different ports can occur in the same cycle.
- A halt change takes effect at the next arbitration edge. An in-flight grant is never revoked.

## Test plan
- Reset release, no requests: all outputs 0 for 5 cycles; owner stays IDLE.
- CPU write then read:
  - Write cpu_addr=0x12, cpu_wdata=0xA5 -> cpu_gnt one cycle after req, mem_we=1, mem_addr=0x12.
  - Then read 0x12 -> cpu_rvalid exactly 2 cycles after the read req edge, rdata=0xA5, dbg_rvalid=0.
- Simultaneous continuous requests with halt=0: grant sequence CPU, DBG, CPU, DBG. No requester waits more than one grant.
- Same request pattern with halt=1: DBG granted whenever eligible; CPU granted only in cycles where DBG is excluded as the current owner.
- Debug writes 0x3C to 0x40 while a CPU read of 0x40 is pending in the same edge with halt=0 and `last`=CPU: DBG write granted first, then CPU read returns 0x3C.
- Reset asserted during a CPU read's grant cycle: cpu_gnt, mem_we and cpu_rvalid go to 0 immediately. After release, no stale rvalid appears.
